// File: rtl/vga_fb_display_if.sv
// Drawing-side port of vga_fb_display.
//
// Groups the host plot/clear controls and the status flags that an animation loop
// watches. The host drives the master modport; the display core takes the slave one.
//
//   colour      [CW]      plot colour, packed {R,G,B}
//   x           [X_BITS]  plot column
//   y           [Y_BITS]  plot row
//   plot        1         write colour at (x,y) this cycle
//   clear       1         pulse: start a full framebuffer clear
//   busy        1         clear engine running
//   frame_start 1         one-cycle pulse at frame wrap
interface vga_fb_display_if #(
  parameter int unsigned CW     = 3,
  parameter int unsigned X_BITS = 8,
  parameter int unsigned Y_BITS = 7
);
  logic [CW-1:0]     colour;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic              plot;
  logic              clear;
  logic              busy;
  logic              frame_start;

  modport master (
    output colour, x, y, plot, clear,
    input  busy, frame_start
  );

  modport slave (
    input  colour, x, y, plot, clear,
    output busy, frame_start
  );
endinterface

// File: rtl/vga_fb_display.sv
// Parametrised VGA display core.
//
// A RES_W x RES_H framebuffer (screen resolution divided by 2**SCALE_LOG2 in each axis)
// written from a host plot port, scanned by a VGA timing generator running at half the
// system clock, and expanded to DAC width per channel. A hardware clear engine fills the
// framebuffer with BACKGROUND, one word per clock, while holding busy high.
//
// Ports:
//   clock      system clock, twice the pixel rate
//   resetn     asynchronous active-low reset (framebuffer contents are kept)
//   host       drawing port (colour/x/y/plot/clear in, busy/frame_start out)
//   VGA_R/G/B  DAC_BITS colour to the DAC, zero while blanked
//   VGA_HS/VS  active-low syncs
//   VGA_BLANK  high while the pixel is visible
//   VGA_SYNC   tied high
//   VGA_CLK    pixel clock; its rising edge sits midway between output updates
module vga_fb_display #(
  parameter int unsigned CH_BITS    = 1,
  parameter int unsigned DAC_BITS   = 10,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned X_BITS     = 8,
  parameter int unsigned Y_BITS     = 7,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic [3*CH_BITS-1:0] BACKGROUND = '0
) (
  input  logic                clock,
  input  logic                resetn,
  vga_fb_display_if.slave     host,
  output logic [DAC_BITS-1:0] VGA_R,
  output logic [DAC_BITS-1:0] VGA_G,
  output logic [DAC_BITS-1:0] VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK,
  output logic                VGA_SYNC,
  output logic                VGA_CLK
);

  localparam int unsigned CW        = 3 * CH_BITS;
  localparam int unsigned RES_W     = H_ACTIVE >> SCALE_LOG2;
  localparam int unsigned RES_H     = V_ACTIVE >> SCALE_LOG2;
  localparam int unsigned FB_WORDS  = RES_W * RES_H;
  localparam int unsigned ADDR_BITS = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_BITS   = $clog2(H_TOTAL);
  localparam int unsigned V_BITS   = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [H_BITS-1:0]    H_LAST    = H_BITS'(H_TOTAL - 1);
  localparam logic [V_BITS-1:0]    V_LAST    = V_BITS'(V_TOTAL - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(FB_WORDS - 1);

  // Enough copies of a channel to cover the DAC width; the top DAC_BITS are kept.
  localparam int unsigned REPS = (DAC_BITS + CH_BITS - 1) / CH_BITS;

  // MSB-first bit replication of one channel up to DAC width.
  function automatic logic [DAC_BITS-1:0] expand_ch(input logic [CH_BITS-1:0] ch);
    logic [REPS*CH_BITS-1:0] wide;
    wide = {REPS{ch}};
    return wide[REPS*CH_BITS-1 -: DAC_BITS];
  endfunction

  // ---------------------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------------------
  typedef enum logic {StIdle, StClearing} state_e;

  state_e               state_q;
  logic [ADDR_BITS-1:0] clr_addr_q;
  logic                 busy_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      clr_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (host.clear) begin
            state_q    <= StClearing;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        StClearing: begin
          // A clear request here is ignored; the sweep never restarts.
          if (clr_addr_q == ADDR_LAST) begin
            state_q    <= StIdle;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign host.busy = busy_q;

  // ---------------------------------------------------------------------------------------
  // Framebuffer write port: clear sweep has priority, then in-range plots from IDLE.
  // ---------------------------------------------------------------------------------------
  logic                 plot_in_range;
  logic [ADDR_BITS-1:0] plot_addr;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [CW-1:0]        wr_data;

  always_comb begin
    // Range check on the full coordinate so an out-of-range x never wraps into the next row.
    plot_in_range = (32'(host.x) < RES_W) && (32'(host.y) < RES_H);
    plot_addr     = ADDR_BITS'(32'(host.y) * RES_W + 32'(host.x));
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr_q;
    wr_data = BACKGROUND;
    if (state_q == StClearing) begin
      wr_en = 1'b1;
    end else if (!host.clear && host.plot && plot_in_range) begin
      wr_en   = 1'b1;
      wr_addr = plot_addr;
      wr_data = host.colour;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Pixel timing
  // ---------------------------------------------------------------------------------------
  logic              phase_q;
  logic              tick;
  logic [H_BITS-1:0] h_q;
  logic [V_BITS-1:0] v_q;
  logic              frame_start_q;

  assign tick = phase_q;

  // Decode of the current counter position (pipeline stage 0).
  int unsigned          h_int;
  int unsigned          v_int;
  logic                 vis_pix;
  logic                 hs_pix;
  logic                 vs_pix;
  logic [ADDR_BITS-1:0] rd_addr;

  always_comb begin
    h_int   = 32'(h_q);
    v_int   = 32'(v_q);
    vis_pix = (h_int < H_ACTIVE) && (v_int < V_ACTIVE);
    hs_pix  = !((h_int >= HS_START) && (h_int < HS_END));
    vs_pix  = !((v_int >= VS_START) && (v_int < VS_END));
    // Only visible positions map into the framebuffer; blanked reads are don't-care.
    rd_addr = '0;
    if (vis_pix) begin
      rd_addr = ADDR_BITS'((v_int >> SCALE_LOG2) * RES_W + (h_int >> SCALE_LOG2));
    end
  end

  // ---------------------------------------------------------------------------------------
  // Framebuffer storage: one write port, tick-enabled synchronous read. No reset.
  // ---------------------------------------------------------------------------------------
  logic [CW-1:0] fb_mem [FB_WORDS];
  logic [CW-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      fb_mem[wr_addr] <= wr_data;
    end
    if (tick) begin
      rd_data_q <= fb_mem[rd_addr];
    end
  end

  // ---------------------------------------------------------------------------------------
  // Counters and the two-tick video pipeline. Stage 1 holds the syncs/blank alongside the
  // framebuffer read so that colour and timing leave the core on the same tick.
  // ---------------------------------------------------------------------------------------
  logic                hs1_q;
  logic                vs1_q;
  logic                vis1_q;
  logic                hs_q;
  logic                vs_q;
  logic                blank_q;
  logic [DAC_BITS-1:0] r_q;
  logic [DAC_BITS-1:0] g_q;
  logic [DAC_BITS-1:0] b_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase_q       <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      vis1_q        <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      phase_q       <= ~phase_q;
      frame_start_q <= 1'b0;
      if (tick) begin
        if (h_q == H_LAST) begin
          h_q <= '0;
          if (v_q == V_LAST) begin
            v_q           <= '0;
            // Counters start at (0,0) out of reset, so the first pulse ends frame one.
            frame_start_q <= 1'b1;
          end else begin
            v_q <= v_q + 1'b1;
          end
        end else begin
          h_q <= h_q + 1'b1;
        end

        hs1_q  <= hs_pix;
        vs1_q  <= vs_pix;
        vis1_q <= vis_pix;

        hs_q    <= hs1_q;
        vs_q    <= vs1_q;
        blank_q <= vis1_q;
        if (vis1_q) begin
          r_q <= expand_ch(rd_data_q[CW-1 -: CH_BITS]);
          g_q <= expand_ch(rd_data_q[2*CH_BITS-1 -: CH_BITS]);
          b_q <= expand_ch(rd_data_q[CH_BITS-1:0]);
        end else begin
          r_q <= '0;
          g_q <= '0;
          b_q <= '0;
        end
      end
    end
  end

  assign host.frame_start = frame_start_q;
  assign VGA_R            = r_q;
  assign VGA_G            = g_q;
  assign VGA_B            = b_q;
  assign VGA_HS           = hs_q;
  assign VGA_VS           = vs_q;
  assign VGA_BLANK        = blank_q;
  assign VGA_SYNC         = 1'b1;
  assign VGA_CLK          = phase_q;

endmodule

// File: tb/tb_vga_fb_display.sv
// Self-checking bench for vga_fb_display, using a shrunken video timing so several whole
// frames fit in a short run. A behavioural model tracks framebuffer contents and the clear
// engine; every clock the bench predicts syncs, blank, colour, busy and frame_start from
// the pixel index since reset.
module tb_vga_fb_display;

  localparam int unsigned CH  = 2;
  localparam int unsigned DAC = 10;
  localparam int unsigned SC  = 2;
  localparam int unsigned XB  = 5;
  localparam int unsigned YB  = 4;
  localparam int unsigned HA  = 64;
  localparam int unsigned HFP = 4;
  localparam int unsigned HSY = 8;
  localparam int unsigned HBP = 4;
  localparam int unsigned VA  = 32;
  localparam int unsigned VFP = 2;
  localparam int unsigned VSY = 2;
  localparam int unsigned VBP = 4;

  localparam int unsigned CW        = 3 * CH;
  localparam int unsigned RW        = HA >> SC;
  localparam int unsigned RH        = VA >> SC;
  localparam int unsigned WORDS     = RW * RH;
  localparam int unsigned HT        = HA + HFP + HSY + HBP;
  localparam int unsigned VT        = VA + VFP + VSY + VBP;
  localparam int unsigned FRAME_CLK = 2 * HT * VT;
  localparam logic [CW-1:0] BG      = 6'b01_10_11;

  logic           clock  = 1'b0;
  logic           resetn = 1'b0;
  logic [DAC-1:0] vga_r;
  logic [DAC-1:0] vga_g;
  logic [DAC-1:0] vga_b;
  logic           vga_hs;
  logic           vga_vs;
  logic           vga_blank;
  logic           vga_sync;
  logic           vga_clk;

  vga_fb_display_if #(.CW(CW), .X_BITS(XB), .Y_BITS(YB)) host ();

  vga_fb_display #(
    .CH_BITS   (CH),
    .DAC_BITS  (DAC),
    .SCALE_LOG2(SC),
    .X_BITS    (XB),
    .Y_BITS    (YB),
    .H_ACTIVE  (HA),
    .H_FP      (HFP),
    .H_SYNC    (HSY),
    .H_BP      (HBP),
    .V_ACTIVE  (VA),
    .V_FP      (VFP),
    .V_SYNC    (VSY),
    .V_BP      (VBP),
    .BACKGROUND(BG)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .host     (host),
    .VGA_R    (vga_r),
    .VGA_G    (vga_g),
    .VGA_B    (vga_b),
    .VGA_HS   (vga_hs),
    .VGA_VS   (vga_vs),
    .VGA_BLANK(vga_blank),
    .VGA_SYNC (vga_sync),
    .VGA_CLK  (vga_clk)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------------------
  logic [CW-1:0] mdl_mem   [WORDS];
  bit            mdl_known [WORDS];
  longint        mdl_stamp [WORDS];  // global edge number of the last write
  longint        gcnt = 0;           // active clock edges, never reset
  int unsigned   ecnt = 0;           // active clock edges since reset release
  bit            mdl_busy = 1'b0;
  int unsigned   mdl_ca = 0;

  task automatic mdl_write(input int unsigned a, input logic [CW-1:0] c);
    mdl_mem[a]   = c;
    mdl_known[a] = 1'b1;
    mdl_stamp[a] = gcnt;
  endtask

  initial begin : model
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        ecnt     = 0;
        mdl_busy = 1'b0;
        mdl_ca   = 0;
      end else begin
        gcnt++;
        ecnt++;
        if (mdl_busy) begin
          mdl_write(mdl_ca, BG);
          mdl_ca++;
          if (mdl_ca == WORDS) mdl_busy = 1'b0;
        end else if (host.clear) begin
          mdl_busy = 1'b1;
          mdl_ca   = 0;
        end else if (host.plot && int'(host.x) < int'(RW) && int'(host.y) < int'(RH)) begin
          mdl_write(int'(host.y) * RW + int'(host.x), host.colour);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Per-clock output checks (sampled on the falling edge)
  // ---------------------------------------------------------------------------------------
  task automatic check_reset_outputs();
    check("rst_busy", 32'(host.busy), 0);
    check("rst_fstart", 32'(host.frame_start), 0);
    check("rst_hs", 32'(vga_hs), 1);
    check("rst_vs", 32'(vga_vs), 1);
    check("rst_blank", 32'(vga_blank), 0);
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    check("rst_clk", 32'(vga_clk), 0);
    check("rst_sync", 32'(vga_sync), 1);
  endtask

  task automatic mon_cycle();
    int unsigned    e, n, p, h, v, a;
    bit             vis;
    longint         rd_edge;
    logic [CW-1:0]  w;
    logic [29:0]    exp_rgb;
    e = ecnt;
    n = e / 2;
    check("vga_clk", 32'(vga_clk), e % 2);
    check("vga_sync", 32'(vga_sync), 1);
    check("busy", 32'(host.busy), 32'(mdl_busy));
    check("frame_start", 32'(host.frame_start), (e != 0 && e % FRAME_CLK == 0) ? 1 : 0);
    if (n < 2) begin
      check("hs_fill", 32'(vga_hs), 1);
      check("vs_fill", 32'(vga_vs), 1);
      check("blank_fill", 32'(vga_blank), 0);
      check("rgb_fill", 32'({vga_r, vga_g, vga_b}), 0);
      return;
    end
    p   = n - 2;
    h   = p % HT;
    v   = (p / HT) % VT;
    vis = (h < HA) && (v < VA);
    check("hs", 32'(vga_hs), (h >= HA + HFP && h < HA + HFP + HSY) ? 0 : 1);
    check("vs", 32'(vga_vs), (v >= VA + VFP && v < VA + VFP + VSY) ? 0 : 1);
    check("blank", 32'(vga_blank), vis ? 1 : 0);
    if (!vis) begin
      check("rgb_blanked", 32'({vga_r, vga_g, vga_b}), 0);
    end else begin
      a = (v >> SC) * RW + (h >> SC);
      // The word was fetched on the tick before last; later writes are not yet visible.
      rd_edge = gcnt - longint'(e - (2 * n - 2));
      if (mdl_known[a] && mdl_stamp[a] < rd_edge) begin
        w       = mdl_mem[a];
        exp_rgb = {{(DAC / CH){w[CW-1 -: CH]}}, {(DAC / CH){w[2*CH-1 -: CH]}},
                   {(DAC / CH){w[CH-1:0]}}};
        check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (!resetn) check_reset_outputs();
      else mon_cycle();
    end
  end

  // Busy run length and frame_start spacing.
  int unsigned busy_run = 0;
  int unsigned last_run = 0;
  int unsigned last_fs  = 0;

  initial begin : run_meter
    forever begin
      @(negedge clock);
      if (host.busy) begin
        busy_run++;
      end else begin
        if (busy_run != 0) last_run = busy_run;
        busy_run = 0;
      end
      if (!resetn) begin
        last_fs = 0;
      end else if (host.frame_start) begin
        if (last_fs != 0) check("fs_gap", ecnt - last_fs, FRAME_CLK);
        last_fs = ecnt;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic plot_px(input int unsigned px, input int unsigned py, input logic [CW-1:0] c);
    host.x      = XB'(px);
    host.y      = YB'(py);
    host.colour = c;
    host.plot   = 1'b1;
    step();
    host.plot   = 1'b0;
  endtask

  task automatic pulse_clear();
    host.clear = 1'b1;
    step();
    host.clear = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    while (host.busy && k < 4 * WORDS) begin
      step();
      k++;
    end
    check("idle_timeout", 32'(host.busy), 0);
    step();
  endtask

  task automatic rand_fill(input int unsigned cnt);
    for (int i = 0; i < int'(cnt); i++) begin
      plot_px($urandom_range(31, 0), $urandom_range(15, 0), CW'($urandom));
    end
  endtask

  task automatic sweep_fill();
    for (int a = 0; a < int'(WORDS); a++) begin
      plot_px(a % RW, a / RW, CW'($urandom));
    end
  endtask

  task automatic run_clocks(input int unsigned cnt);
    repeat (cnt) step();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    host.colour = '0;
    host.x      = '0;
    host.y      = '0;
    host.plot   = 1'b0;
    host.clear  = 1'b0;
    resetn      = 1'b0;
    run_clocks(3);
    resetn = 1'b1;

    // Initialise the framebuffer, then draw random content and the landmark pixels.
    pulse_clear();
    wait_idle();
    check("clear_len_init", last_run, WORDS);
    sweep_fill();
    rand_fill(200);
    plot_px(5, 3, 6'b11_00_11);
    plot_px(RW, 0, 6'b11_11_11);   // one past the last column: must not land on (0,1)
    plot_px(2, RH, 6'b11_11_11);   // one past the last row
    run_clocks(FRAME_CLK + 20);

    // Clear over random content; a plot 100 clocks in must be dropped.
    rand_fill(100);
    pulse_clear();
    run_clocks(99);
    plot_px(3, 2, 6'b11_11_11);
    wait_idle();
    check("clear_len_plot", last_run, WORDS);
    run_clocks(FRAME_CLK + 20);

    // clear and plot together, then a second clear request mid-sweep.
    rand_fill(60);
    host.x      = XB'(7);
    host.y      = YB'(1);
    host.colour = 6'b00_11_00;
    host.plot   = 1'b1;
    host.clear  = 1'b1;
    step();
    host.plot   = 1'b0;
    host.clear  = 1'b0;
    run_clocks(49);
    pulse_clear();
    wait_idle();
    check("clear_len_repulse", last_run, WORDS);
    run_clocks(FRAME_CLK + 20);

    // Reset in the middle of a clear: sweep stops, untouched words keep their content.
    sweep_fill();
    pulse_clear();
    run_clocks(59);
    resetn = 1'b0;
    #1;
    check("abort_busy", 32'(host.busy), 0);
    check("abort_hs", 32'(vga_hs), 1);
    check("abort_blank", 32'(vga_blank), 0);
    check("abort_clk", 32'(vga_clk), 0);
    run_clocks(3);
    resetn = 1'b1;
    run_clocks(2 * FRAME_CLK + 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_display.md
Name: vga_fb_display

Overview:
- Parametrised VGA display core: a framebuffer with a plot write port, a parameterised 640x480-class timing generator, and DAC-width colour expansion.
- Supersedes the fixed 160x120, 3-bit-colour VGA stub.
- Adds a hardware clear engine with a busy flag, and a frame-start pulse for host animation loops.
- Sits between user drawing logic and the board video DAC.

Parameters:
CH_BITS, 1, colour bits per channel; colour word CW = 3*CH_BITS, packed {R,G,B}
DAC_BITS, 10, DAC width per channel
SCALE_LOG2, 2, log2 of the screen pixels per framebuffer pixel in each axis
X_BITS, 8, x coordinate width
Y_BITS, 7, y coordinate width
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, horizontal sync width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines
BACKGROUND, 0, CW-bit clear colour

Ports:
clock  in  1  system clock, twice the pixel rate
resetn  in  1  asynchronous active-low reset
colour  in  CW  plot colour
x  in  X_BITS  plot column
y  in  Y_BITS  plot row
plot  in  1  write colour at (x,y) this cycle
clear  in  1  pulse; start a full framebuffer clear
busy  out  1  clear engine running
frame_start  out  1  one-cycle pulse at frame wrap
VGA_R  out  DAC_BITS  red to DAC
VGA_G  out  DAC_BITS  green to DAC
VGA_B  out  DAC_BITS  blue to DAC
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
VGA_BLANK  out  1  high when visible, low when blanked
VGA_SYNC  out  1  tied 1
VGA_CLK  out  1  pixel clock to DAC

Behaviour:
- Derived constants:
  - RES_W = H_ACTIVE>>SCALE_LOG2; RES_H = V_ACTIVE>>SCALE_LOG2.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Framebuffer:
  - RES_W*RES_H words of CW bits, addr = y*RES_W + x.
  - One write port on clock; synchronous read with 1-clock latency.
  - Contents are not affected by reset.
- Plot:
  - Write occurs only if x<RES_W, y<RES_H, and state is IDLE.
  - Out-of-range writes are dropped; no address aliasing.
- Pixel tick:
  - Phase flop toggles every clock; tick = phase==1.
  - VGA_CLK = phase, so the DAC samples on its rising edge midway between output updates.
- Counters:
  - h counts 0..H_TOTAL-1 and advances on tick.
  - v increments when h wraps; v wraps at V_TOTAL.
- Video pipeline, 2 ticks:
  - Read address = (v>>SCALE_LOG2)*RES_W + (h>>SCALE_LOG2).
  - Outputs registered on tick N reflect counter values from tick N-2; syncs and blank are delayed identically.
  - HS low while h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VS uses the same rule with v and the vertical parameters.
  - BLANK high iff h<H_ACTIVE and v<V_ACTIVE.
  - RGB = 0 when blanked; otherwise each CH_BITS field is bit-replicated MSB-first to DAC_BITS.
- frame_start:
  - High for exactly one clock, on the clock edge where the counters wrap to (0,0).
  - Not asserted during the first frame after reset.
- Clear FSM, states IDLE and CLEARING:
  - IDLE -> CLEARING on clear: busy=1, address counter=0.
  - CLEARING writes BACKGROUND at the address counter each clock and increments it.
  - After address RES_W*RES_H-1 is written, return to IDLE and drop busy.
  - busy is high for exactly RES_W*RES_H clocks.
- Collision rules:
  - Plot while busy: dropped.
  - clear and plot in the same IDLE cycle: clear wins, plot dropped.
  - clear while CLEARING: ignored, no restart.
- Video scan continues during a clear and may show partially cleared content.
- Reset values:
  - h, v, phase, and clear address = 0; state IDLE.
  - busy=0, frame_start=0, VGA_HS=1, VGA_VS=1, VGA_BLANK=0, RGB=0, VGA_CLK=0, VGA_SYNC=1.
- Reset asserted mid-clear aborts immediately: busy=0, remaining words unchanged.

Test Plan:
- Reset, then release and run 2 frames -> HS falls every 1600 clocks and is low 192 clocks. VS period is 840000 clocks and it is low for 3200 clocks. frame_start is spaced 840000 clocks apart.
- Plot (5,3) colour 3'b101 -> visible pixels h 20..23, v 12..15 drive R=10'h3FF, G=0, B=10'h3FF. Neighbouring pixels show prior content. Blanked intervals have RGB=0.
- Plot x=160, y=0 colour 3'b111 -> no write. Framebuffer address 160, pixel (0,1), is unchanged.
- clear after random fill -> busy=1 for exactly 19200 clocks. A plot at clock 100 of the clear is dropped. The next frame shows all BACKGROUND.
- clear and plot asserted in the same cycle, then clear re-pulsed at clock 50 -> the plot is lost. busy still ends 19200 clocks after the first clear.
- resetn low at clock 5000 of a clear -> busy=0 asynchronously and outputs return to their reset values. Addresses 0..4999 hold BACKGROUND; the rest are unchanged.
